// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// datapath mux selects and the control-word payload.
package mcu_pkg;

   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the IR/memory/datapath side (master) and the control unit (slave).
interface multicycle_control_unit_if #(
   parameter int unsigned OPCODE_W = 6
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                PCWrite;
   logic                PCWriteCond;
   logic                IorD;
   logic                MemRead;
   logic                MemWrite;
   logic                IRWrite;
   logic                MemtoReg;
   logic                RegDst;
   logic                RegWrite;
   logic                ALUSrcA;
   logic [1:0]          ALUSrcB;
   logic [1:0]          ALUOp;
   logic [1:0]          PCSource;
   logic [3:0]          state;
   logic                illegal_op;
   logic                instr_done;

   modport master (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state,
             illegal_op, instr_done
   );

   modport slave (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state,
             illegal_op, instr_done
   );
endinterface

// File: rtl/mcu_output_decode.sv
// Moore output map: control word from the current state, with memory-state
// strobes qualified by the effective memory-ready.
module mcu_output_decode
   import mcu_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   input  logic               mem_ready_eff_i,
   output ctrl_t              ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.ir_write  = mem_ready_eff_i;
            ctrl_o.pc_write  = mem_ready_eff_i;
         end
         S_DECODE:    ctrl_o.alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEM_READ: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         // Write strobe stays up while the memory stalls; done only on completion
         S_MEM_WRITE: begin
            ctrl_o.iord       = 1'b1;
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.instr_done = mem_ready_eff_i;
         end
         S_EXECUTE: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            ctrl_o.reg_dst    = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_RT;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.instr_done    = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_write   = 1'b1;
            ctrl_o.pc_source  = PCSRC_JUMP;
            ctrl_o.instr_done = 1'b1;
         end
         S_ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_ADDI_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.instr_done = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing by
// opcode and memory handshake, illegal-opcode pulse.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int unsigned OPCODE_W      = 6,
   parameter bit          USE_MEM_READY = 1'b1,
   parameter bit          SUPPORT_ADDI  = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_control_unit_if.slave bus
);

   logic               mem_ready_eff;
   logic               is_rtype, is_lw, is_sw, is_beq, is_j, is_addi;
   logic [STATE_W-1:0] state_q, state_d;
   logic               illegal_q, illegal_d;
   ctrl_t              ctrl_dec, ctrl;

   assign mem_ready_eff = bus.mem_ready | ~USE_MEM_READY;

   assign is_rtype = (bus.opcode == OPCODE_W'(OP_RTYPE));
   assign is_lw    = (bus.opcode == OPCODE_W'(OP_LW));
   assign is_sw    = (bus.opcode == OPCODE_W'(OP_SW));
   assign is_beq   = (bus.opcode == OPCODE_W'(OP_BEQ));
   assign is_j     = (bus.opcode == OPCODE_W'(OP_J));
   assign is_addi  = SUPPORT_ADDI && (bus.opcode == OPCODE_W'(OP_ADDI));

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH: if (mem_ready_eff) state_d = S_DECODE;
         S_DECODE: begin
            if (is_lw || is_sw) state_d = S_MEM_ADDR;
            else if (is_rtype)  state_d = S_EXECUTE;
            else if (is_beq)    state_d = S_BRANCH;
            else if (is_j)      state_d = S_JUMP;
            else if (is_addi)   state_d = S_ADDI_EX;
            else begin
               state_d   = S_FETCH;
               illegal_d = 1'b1;
            end
         end
         // Opcode is re-sampled here; anything but LW/SW restarts cleanly
         S_MEM_ADDR: begin
            if (is_lw)      state_d = S_MEM_READ;
            else if (is_sw) state_d = S_MEM_WRITE;
            else            state_d = S_FETCH;
         end
         S_MEM_READ:  if (mem_ready_eff) state_d = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready_eff) state_d = S_FETCH;
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ADDI_EX:   state_d = S_ADDI_WB;
         default:     state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   mcu_output_decode u_dec (
      .state_i         (state_q),
      .mem_ready_eff_i (mem_ready_eff),
      .ctrl_o          (ctrl_dec)
   );

   // Reset kills every strobe immediately, without waiting for a clock
   assign ctrl = reset ? '0 : ctrl_dec;

   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.IorD        = ctrl.iord;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.RegDst      = ctrl.reg_dst;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.ALUOp       = ctrl.alu_op;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.instr_done  = ctrl.instr_done;
   assign bus.state       = state_q;
   assign bus.illegal_op  = illegal_q;

endmodule
